// File: rtl/nlc_pkg.sv
// nlc_pkg: shared float/fixed constants and collector FSM states
package nlc_pkg;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS = 127;
  localparam int XLIN_W = 21;
  localparam int NUM_CH = 16;
  localparam int TAG_W = 4;
  localparam logic signed [XLIN_W-1:0] XLIN_MAX = {1'b0, {(XLIN_W-1){1'b1}}};
  localparam logic signed [XLIN_W-1:0] XLIN_MIN = {1'b1, {(XLIN_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
endpackage

// File: rtl/nlc_output_collector_if.sv
// nlc_output_collector_if: frame/sample stream from the polynomial adder
interface nlc_output_collector_if;
  logic frame_start;
  logic [31:0] fp_in;
  logic fp_srdyi;
  modport master(output frame_start, fp_in, fp_srdyi);
  modport slave(input frame_start, fp_in, fp_srdyi);
endinterface

// File: rtl/nlc_fp2fix.sv
// nlc_fp2fix: 2-stage float-to-fixed truncating converter with channel tag passthrough
module nlc_fp2fix import nlc_pkg::*; #(
  parameter int FRAC_BITS = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic [31:0] fp,
  input  logic fp_vld,
  input  logic [TAG_W-1:0] fp_tag,
  output logic x_vld,
  output logic [TAG_W-1:0] x_tag,
  output logic signed [XLIN_W-1:0] x_lin,
  output logic x_sat,
  output logic busy
);
  logic sgn, big, nan, v1, s1, b1, n1, ovf;
  logic [FP_EXP_W-1:0] e;
  logic [FP_MAN_W-1:0] m;
  logic signed [10:0] sh;
  logic [XLIN_W-1:0] mag, m1;
  logic [TAG_W-1:0] t1;
  logic signed [XLIN_W-1:0] lin;
  // sh is the bit position of the hidden one in the scaled result
  always_comb begin
    {sgn, e, m} = fp;
    sh = $signed({3'b000, e}) - 11'(FP_BIAS) + 11'(FRAC_BITS);
    big = e == '1 || sh > 11'sd20;
    nan = e == '1 && m != '0;
    mag = (e == '0 || sh < 0 || big) ? '0 : XLIN_W'({1'b1, m} >> (5'd23 - 5'(sh)));
  end
  always_comb begin
    ovf = b1 || m1 > (s1 ? 21'h100000 : 21'h0FFFFF);
    lin = n1 ? XLIN_MAX : ovf ? (s1 ? XLIN_MIN : XLIN_MAX) : s1 ? -m1 : m1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {v1, s1, b1, n1, x_vld, x_sat} <= '0;
      t1 <= '0;
      m1 <= '0;
      x_tag <= '0;
      x_lin <= '0;
    end else begin
      v1 <= fp_vld;
      t1 <= fp_tag;
      s1 <= sgn;
      b1 <= big;
      n1 <= nan;
      m1 <= mag;
      x_vld <= v1;
      x_tag <= t1;
      x_lin <= lin;
      x_sat <= v1 && ovf;
    end
  end
  assign busy = v1 || x_vld;
endmodule

// File: rtl/nlc_output_collector.sv
// nlc_output_collector: tags converted samples by channel, banks them and flags frame completion
module nlc_output_collector #(
  parameter int FRAC_BITS = 0,
  parameter int NUM_CH = 16
) (
  input  logic clk,
  input  logic rst,
  nlc_output_collector_if.slave bus,
  output logic signed [20:0] ch0_x_lin,
  output logic signed [20:0] ch1_x_lin,
  output logic signed [20:0] ch2_x_lin,
  output logic signed [20:0] ch3_x_lin,
  output logic signed [20:0] ch4_x_lin,
  output logic signed [20:0] ch5_x_lin,
  output logic signed [20:0] ch6_x_lin,
  output logic signed [20:0] ch7_x_lin,
  output logic signed [20:0] ch8_x_lin,
  output logic signed [20:0] ch9_x_lin,
  output logic signed [20:0] ch10_x_lin,
  output logic signed [20:0] ch11_x_lin,
  output logic signed [20:0] ch12_x_lin,
  output logic signed [20:0] ch13_x_lin,
  output logic signed [20:0] ch14_x_lin,
  output logic signed [20:0] ch15_x_lin,
  output logic srdyo,
  output logic sat_flag,
  output logic busy
);
  import nlc_pkg::*;
  localparam logic [TAG_W-1:0] LAST = TAG_W'(NUM_CH - 1);
  state_t state, state_nxt;
  logic [TAG_W-1:0] cnt, cnt_eff, cnt_nxt, x_tag;
  logic last_acc, wr_last, x_vld, x_sat, pipe_busy;
  logic signed [XLIN_W-1:0] x_lin;
  logic signed [XLIN_W-1:0] bank [16];
  nlc_fp2fix #(.FRAC_BITS(FRAC_BITS)) u_fp2fix (
    .clk(clk), .rst(rst), .fp(bus.fp_in), .fp_vld(bus.fp_srdyi), .fp_tag(cnt_eff),
    .x_vld(x_vld), .x_tag(x_tag), .x_lin(x_lin), .x_sat(x_sat), .busy(pipe_busy)
  );
  // frame_start rebases the counter in the same cycle so a coincident sample is channel 0
  always_comb begin
    cnt_eff = bus.frame_start ? '0 : cnt;
    last_acc = bus.fp_srdyi && cnt_eff == LAST;
    cnt_nxt = !bus.fp_srdyi ? cnt_eff : last_acc ? '0 : cnt_eff + 1'b1;
    wr_last = x_vld && x_tag == LAST;
    srdyo = state == DONE;
    state_nxt = state;
    case (state)
      IDLE, COLLECT, DONE: state_nxt = last_acc ? DRAIN : cnt_nxt != '0 ? COLLECT : IDLE;
      DRAIN: state_nxt = wr_last ? DONE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sat_flag <= 1'b0;
      bank <= '{default: '0};
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      sat_flag <= (sat_flag && !(bus.frame_start || (bus.fp_srdyi && cnt_eff == '0))) || (x_vld && x_sat);
      if (x_vld) bank[x_tag] <= x_lin;
    end
  end
  assign busy = cnt != '0 || pipe_busy;
  assign ch0_x_lin = bank[0];
  assign ch1_x_lin = bank[1];
  assign ch2_x_lin = bank[2];
  assign ch3_x_lin = bank[3];
  assign ch4_x_lin = bank[4];
  assign ch5_x_lin = bank[5];
  assign ch6_x_lin = bank[6];
  assign ch7_x_lin = bank[7];
  assign ch8_x_lin = bank[8];
  assign ch9_x_lin = bank[9];
  assign ch10_x_lin = bank[10];
  assign ch11_x_lin = bank[11];
  assign ch12_x_lin = bank[12];
  assign ch13_x_lin = bank[13];
  assign ch14_x_lin = bank[14];
  assign ch15_x_lin = bank[15];
endmodule

// File: tb/tb_nlc_output_collector.sv
// tb_nlc_output_collector: directed checks of conversion, framing, saturation and reset
module tb_nlc_output_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  nlc_output_collector_if b();
  nlc_output_collector_if b4();
  logic signed [20:0] ch [16];
  logic signed [20:0] c4 [16];
  logic srdyo, sat_flag, busy, srdyo4, sat4, busy4;
  int tests = 0, fails = 0, npulse = 0, p;
  int z [16], ea [16], eb [16], ed [16], ee [16], ef [16], eg [16];
  nlc_output_collector #(.FRAC_BITS(0)) dut (
    .clk(clk), .rst(rst), .bus(b),
    .ch0_x_lin(ch[0]), .ch1_x_lin(ch[1]), .ch2_x_lin(ch[2]), .ch3_x_lin(ch[3]),
    .ch4_x_lin(ch[4]), .ch5_x_lin(ch[5]), .ch6_x_lin(ch[6]), .ch7_x_lin(ch[7]),
    .ch8_x_lin(ch[8]), .ch9_x_lin(ch[9]), .ch10_x_lin(ch[10]), .ch11_x_lin(ch[11]),
    .ch12_x_lin(ch[12]), .ch13_x_lin(ch[13]), .ch14_x_lin(ch[14]), .ch15_x_lin(ch[15]),
    .srdyo(srdyo), .sat_flag(sat_flag), .busy(busy)
  );
  nlc_output_collector #(.FRAC_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .bus(b4),
    .ch0_x_lin(c4[0]), .ch1_x_lin(c4[1]), .ch2_x_lin(c4[2]), .ch3_x_lin(c4[3]),
    .ch4_x_lin(c4[4]), .ch5_x_lin(c4[5]), .ch6_x_lin(c4[6]), .ch7_x_lin(c4[7]),
    .ch8_x_lin(c4[8]), .ch9_x_lin(c4[9]), .ch10_x_lin(c4[10]), .ch11_x_lin(c4[11]),
    .ch12_x_lin(c4[12]), .ch13_x_lin(c4[13]), .ch14_x_lin(c4[14]), .ch15_x_lin(c4[15]),
    .srdyo(srdyo4), .sat_flag(sat4), .busy(busy4)
  );
  always @(posedge clk) if (srdyo) npulse <= npulse + 1;
  task automatic check(string tag, int got, int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic put(logic [31:0] v, logic fs = 1'b0);
    b.fp_in = v;
    b.fp_srdyi = 1'b1;
    b.frame_start = fs;
    step();
    b.fp_srdyi = 1'b0;
    b.frame_start = 1'b0;
  endtask
  task automatic put4(logic [31:0] v);
    b4.fp_in = v;
    b4.fp_srdyi = 1'b1;
    step();
    b4.fp_srdyi = 1'b0;
  endtask
  task automatic check_bank(string tag, int e [16]);
    for (int i = 0; i < 16; i++) check($sformatf("%s_ch%0d", tag, i), ch[i], e[i]);
  endtask
  // integer-valued single-precision encoding, |n| < 2^24
  function automatic logic [31:0] f2b(int n);
    int a, q;
    a = n < 0 ? -n : n;
    if (a == 0) return 32'h0;
    q = 0;
    for (int i = 0; i < 31; i++) if ((a >> i) != 0) q = i;
    return {n < 0, 8'(127 + q), 23'(a << (23 - q))};
  endfunction
  initial begin
    {b.frame_start, b.fp_srdyi, b4.frame_start, b4.fp_srdyi} = '0;
    b.fp_in = '0;
    b4.fp_in = '0;
    for (int i = 0; i < 16; i++) begin
      z[i] = 0;
      ea[i] = i % 2 ? -3 : 3;
      eb[i] = 1;
      ed[i] = (i + 1) * 1111 * (i % 2 ? -1 : 1);
      ee[i] = (i % 3 == 0 ? -1 : 1) * (i * 61357 + 5);
      ef[i] = -(i + 7) * 13;
      eg[i] = i == 0 ? 7 : 300 + i;
    end
    eb[5] = 1048575; eb[6] = -1048576; eb[7] = 1048575; eb[8] = -1048576;
    step(); step();
    rst = 1'b0;
    check_bank("rst", z);
    check("rst_srdyo", srdyo, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_busy", busy, 0);
    // alternating +/-3, consecutive samples
    p = npulse;
    for (int i = 0; i < 16; i++) put(i % 2 ? 32'hC0400000 : 32'h40400000);
    check("a_srdyo_k0", srdyo, 0);
    check("a_busy", busy, 1);
    step(); check("a_srdyo_k1", srdyo, 0);
    step(); check("a_srdyo_k2", srdyo, 1); check("a_sat", sat_flag, 0);
    step(); check("a_srdyo_k3", srdyo, 0); check("a_busy_end", busy, 0);
    check_bank("a", ea);
    check("a_pulses", npulse - p, 1);
    // saturation corners
    for (int i = 0; i < 16; i++)
      put(i == 5 ? 32'h49800000 : i == 6 ? 32'hFF800000 : i == 7 ? 32'h7FC00000 : i == 8 ? 32'hC9800000 : 32'h3F800000);
    step(); step();
    check("b_srdyo", srdyo, 1);
    check("b_sat", sat_flag, 1);
    check_bank("b", eb);
    step();
    // random gaps, then a back-to-back frame
    p = npulse;
    for (int i = 0; i < 16; i++) begin
      put(f2b(ed[i]));
      if (i == 0) check("d_satclr", sat_flag, 0);
      if (i < 15) repeat ($urandom_range(0, 5)) step();
    end
    for (int j = 0; j < 16; j++) begin
      put(f2b(ee[j]));
      if (j == 0) check("d_srdyo_k1", srdyo, 0);
      if (j == 1) begin check("d_srdyo_k2", srdyo, 1); check_bank("d", ed); end
      if (j == 2) check("d_srdyo_k3", srdyo, 0);
    end
    step(); check("e_srdyo_k1", srdyo, 0);
    step(); check("e_srdyo_k2", srdyo, 1);
    step(); check("e_srdyo_k3", srdyo, 0);
    check_bank("e", ee);
    check("de_pulses", npulse - p, 2);
    // reset mid-frame
    p = npulse;
    for (int i = 0; i < 10; i++) put(f2b(i + 1));
    rst = 1'b1; step(); rst = 1'b0;
    check_bank("f_rst", z);
    check("f_busy", busy, 0);
    check("f_sat", sat_flag, 0);
    step(); step(); step();
    check("f_nopulse", npulse - p, 0);
    for (int i = 0; i < 16; i++) put(f2b(ef[i]));
    step(); step(); check("f_srdyo", srdyo, 1);
    step();
    check_bank("f", ef);
    check("f_pulses", npulse - p, 1);
    // frame_start abandons a partial frame
    p = npulse;
    for (int i = 0; i < 10; i++) put(f2b(200 + i));
    put(f2b(7), 1'b1);
    step(); step();
    check("g_ch0", ch[0], 7);
    check("g_ch9_kept", ch[9], 209);
    check("g_nopulse", npulse - p, 0);
    for (int i = 1; i < 16; i++) put(f2b(eg[i]));
    step(); step(); check("g_srdyo", srdyo, 1);
    step();
    check_bank("g", eg);
    check("g_pulses", npulse - p, 1);
    // FRAC_BITS=4 instance
    put4(32'h3FC00000); put4(32'hBF900000); put4(32'h3D800000);
    put4(32'h3D000000); put4(32'hC7800000); put4(32'h47800000);
    step();
    check("q_neg_edge", c4[4], -1048576);
    check("q_sat_clear", sat4, 0);
    step();
    check("q_pos_sat", c4[5], 1048575);
    check("q_sat_set", sat4, 1);
    check("q_1p5", c4[0], 24);
    check("q_m1p125", c4[1], -18);
    check("q_lsb", c4[2], 1);
    check("q_half_lsb", c4[3], 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nlc_output_collector.md
NLC_OUTPUT_COLLECTOR -- requirements
Module: nlc_output_collector

Interface
REQ-001 Parameter FRAC_BITS, default 0: number of fractional bits in each 21-bit output word.
REQ-002 Parameter NUM_CH, default 16: number of channels per frame.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 frame_start  input  1  one-cycle pulse that begins a new frame.
REQ-006 fp_in  input  32  IEEE-754 single-precision polynomial result from the adder.
REQ-007 fp_srdyi  input  1  fp_in valid this cycle; results arrive in channel order 0..NUM_CH-1.
REQ-008 chN_x_lin (N=0..15)  output  21  signed two's-complement linearised result per channel.
REQ-009 srdyo  output  1  one-cycle pulse when all NUM_CH channels of the frame are written.
REQ-010 sat_flag  output  1  at least one channel in the current frame saturated.
REQ-011 busy  output  1  frame partially collected: channel count nonzero, or conversion in flight.

Function
REQ-012 Conversion truncates toward zero: value = trunc(fp_in * 2^FRAC_BITS).
REQ-013 Zero and denormal inputs convert to 0.
REQ-014 Saturation: magnitude > 2^20-1 saturates to +1048575 (positive) or -1048576 (negative); exactly -2^20 converts without a saturation event.
REQ-015 Infinity saturates by sign; NaN saturates to +1048575; every saturation event sets sat_flag.
REQ-016 Conversion pipeline is 2 stages.
- Stage 1: unpack, align/shift.
- Stage 2: saturate, negate, register.
REQ-017 Latency: a sample taken at edge k updates its chN_x_lin register at edge k+2; one sample per cycle sustained, no backpressure.
REQ-018 Channel counter (0..NUM_CH-1) selects the destination register.
- Advances only on accepted fp_srdyi; gaps of any length allowed.
- Wraps to 0 after NUM_CH-1.
REQ-019 FSM states and transitions:
- IDLE: counter 0. Sample -> COLLECT.
- COLLECT: after sample NUM_CH-1 -> DRAIN.
- DRAIN: wait for the last write -> DONE.
- DONE: srdyo=1 for exactly one cycle -> IDLE.
REQ-020 srdyo asserts in the cycle after edge k+2, where k is the edge that sampled channel NUM_CH-1.
REQ-021 Back-to-back frames are supported: a sample in DRAIN or DONE is channel 0 of the next frame and does not delay srdyo.
REQ-022 frame_start resets the counter to 0.
- A partial frame is abandoned: no srdyo; registers already written keep their values.
- Conversions in flight still complete into their tagged channels.
REQ-023 frame_start and fp_srdyi in the same cycle: the sample is channel 0 of the new frame.
REQ-024 sat_flag clears on frame_start or on the channel-0 sample of a new frame, is set by any saturation in that frame, and holds through srdyo until cleared.
REQ-025 chN_x_lin hold their values until overwritten by the next frame.

Reset
REQ-026 While rst is high at a clock edge:
- Counter, pipeline valids and tags clear; FSM goes to IDLE.
- All chN_x_lin = 0; srdyo = 0, sat_flag = 0, busy = 0.
REQ-027 Reset mid-frame or mid-pipeline discards in-flight samples; no write and no srdyo follow.
REQ-028 Reset has priority over frame_start and fp_srdyi in the same cycle.

Structure
REQ-029 Shared package nlc_pkg holds:
- FP_EXP_W=8, FP_MAN_W=23, FP_BIAS=127.
- XLIN_W=21, NUM_CH=16.
- XLIN_MAX / XLIN_MIN constants.
- FSM state enumeration.
REQ-030 Sub-module nlc_fp2fix implements the 2-stage float-to-fixed pipeline with valid and 4-bit channel tag passthrough plus a sat output; nlc_output_collector holds the counter, FSM and register bank.

Verification
REQ-031 FRAC_BITS=0; 16 consecutive samples 0x40400000 (3.0) through 0xC0400000 (-3.0), alternating -> channels alternate 3/-3; srdyo is a single pulse 2 cycles after the last sample; sat_flag=0.
REQ-032 Ch5=0x49800000 (1048576.0), ch6=0xFF800000 (-inf), ch7=0x7FC00000 (NaN), ch8=0xC9800000 (-1048576.0) -> 1048575, -1048576, 1048575, -1048576; sat_flag=1.
REQ-033 FRAC_BITS=4; 0x3FC00000 (1.5) -> 24; 0xBF900000 (-1.125) -> -18; 0x3D800000 (0.0625) -> 1; 0x3D000000 (0.03125) -> 0.
REQ-034 Samples with random 0-5 cycle gaps, then a second frame issued back-to-back with no idle cycle -> exactly two srdyo pulses, each 2 cycles after that frame's 16th sample; all registers correct.
REQ-035 Reset after sample 9 -> all outputs 0; the next 16 samples fill ch0..ch15 and give one srdyo.
REQ-036 frame_start after sample 9, coincident with a sample -> that sample lands in ch0; no srdyo for the abandoned frame; srdyo follows 16 samples later.
